serial_subtractor: RTL and testbench

- Bit-serial, LSB-first N-bit subtractor. Computes Diff = Xin − Yin − Bin, one bit per clock, using a single full-subtractor cell with a registered borrow.
- Complements the combinational adder datapath. Serves as an area-minimal arithmetic unit for lab datapaths where latency is acceptable.
- Uses a Start/Busy/Done handshake. The result is held stable between operations.

---
 rtl/serial_subtractor_if.sv | 23 ++
 rtl/serial_subtractor.sv | 94 +++++++++
 tb/tb_serial_subtractor.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Start/Busy/Done handshake bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             Start;
    logic [WIDTH-1:0] Xin;
    logic [WIDTH-1:0] Yin;
    logic             Bin;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, Xin, Yin, Bin,
        input  Diff, Bout, Busy, Done
    );

    modport slave (
        input  Start, Xin, Yin, Bin,
        output Diff, Bout, Busy, Done
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: Diff = Xin - Yin - Bin, one bit per clock.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic                Clk,
    input logic                Reset,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FINISH
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_b;
    logic             r_bout;
    logic [CW-1:0]    r_cnt;
    logic             w_d;
    logic             w_b_next;
    logic             w_last;
    logic             w_load;
    logic [WIDTH-1:0] w_res_next;

    // Single full-subtractor cell
    assign w_d        = r_x[0] ^ r_y[0] ^ r_b;
    assign w_b_next   = (~r_x[0] & r_y[0]) | (~(r_x[0] ^ r_y[0]) & r_b);
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE, S_FINISH: begin
                if (bus.Start) begin
                    w_load       = 1'b1;
                    w_state_next = S_SHIFT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (w_last) w_state_next = S_FINISH;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_res   <= '0;
            r_diff  <= '0;
            r_b     <= 1'b0;
            r_bout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_x   <= bus.Xin;
                r_y   <= bus.Yin;
                r_b   <= bus.Bin;
                r_res <= '0;
                r_cnt <= '0;
            end else if (r_state == S_SHIFT) begin
                r_x   <= r_x >> 1;
                r_y   <= r_y >> 1;
                r_b   <= w_b_next;
                r_res <= w_res_next;
                r_cnt <= r_cnt + 1'b1;
                // Published result only changes on the Done edge
                if (w_last) begin
                    r_diff <= w_res_next;
                    r_bout <= w_b_next;
                end
            end
        end
    end

    assign bus.Diff = r_diff;
    assign bus.Bout = r_bout;
    assign bus.Busy = (r_state == S_SHIFT);
    assign bus.Done = (r_state == S_FINISH);
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector and sweep bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         b;
        logic [W-1:0] ed;
        logic         eb;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    logic [W-1:0] prev_diff;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bus.slave)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic b, output logic [W-1:0] d,
                          output logic bo, output int lat,
                          output int busyc, output logic hold_ok);
        bus.Start = 1'b1;
        bus.Xin   = x;
        bus.Yin   = y;
        bus.Bin   = b;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        bus.Xin   = W'($urandom);
        bus.Yin   = W'($urandom);
        bus.Bin   = 1'($urandom);
        lat     = 0;
        busyc   = bus.Busy ? 1 : 0;
        hold_ok = 1'b1;
        while (!bus.Done && lat < 20) begin
            if (bus.Diff !== prev_diff) hold_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
            if (bus.Busy) busyc++;
        end
        d  = bus.Diff;
        bo = bus.Bout;
    endtask

    initial begin
        vec_t         tbl[10];
        logic [W-1:0] d;
        logic         bo;
        int           lat;
        int           busyc;
        logic         hold_ok;
        logic [W:0]   ref9;
        int           n;
        int           done1;
        int           done2;
        int           ndone;

        tbl[0] = '{8'd100, 8'd37,  1'b0, 8'd63,  1'b0};
        tbl[1] = '{8'd5,   8'd10,  1'b0, 8'd251, 1'b1};
        tbl[2] = '{8'd0,   8'd0,   1'b1, 8'd255, 1'b1};
        tbl[3] = '{8'd255, 8'd255, 1'b0, 8'd0,   1'b0};
        tbl[4] = '{8'd0,   8'd255, 1'b1, 8'd0,   1'b1};
        tbl[5] = '{8'd200, 8'd100, 1'b1, 8'd99,  1'b0};
        tbl[6] = '{8'd128, 8'd127, 1'b0, 8'd1,   1'b0};
        tbl[7] = '{8'd0,   8'd1,   1'b0, 8'd255, 1'b1};
        tbl[8] = '{8'd255, 8'd0,   1'b1, 8'd254, 1'b0};
        tbl[9] = '{8'd10,  8'd10,  1'b1, 8'd255, 1'b1};

        rst       = 1'b1;
        bus.Start = 1'b0;
        bus.Xin   = '0;
        bus.Yin   = '0;
        bus.Bin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.Busy), 0);
        chk("rst_done", 32'(bus.Done), 0);
        chk("rst_diff", 32'(bus.Diff), 0);
        chk("rst_bout", 32'(bus.Bout), 0);
        rst       = 1'b0;
        prev_diff = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].x, tbl[i].y, tbl[i].b, d, bo, lat, busyc, hold_ok);
            chk($sformatf("vec%0d_diff", i), 32'(d), 32'(tbl[i].ed));
            chk($sformatf("vec%0d_bout", i), 32'(bo), 32'(tbl[i].eb));
            chk($sformatf("vec%0d_lat", i), lat, W);
            chk($sformatf("vec%0d_busy", i), busyc, W);
            chk($sformatf("vec%0d_hold", i), 32'(hold_ok), 1);
            prev_diff = tbl[i].ed;
        end

        // Done is a single-cycle pulse
        @(posedge clk);
        #1;
        chk("done_pulse", 32'(bus.Done), 0);

        // Start held high; operands change after acceptance
        bus.Start = 1'b1;
        bus.Xin   = 8'd50;
        bus.Yin   = 8'd20;
        bus.Bin   = 1'b0;
        @(posedge clk);
        #1;
        bus.Xin = 8'd7;
        bus.Yin = 8'd9;
        bus.Bin = 1'b1;
        n     = 0;
        done1 = -1;
        done2 = -1;
        while (n < 40 && done2 < 0) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.Done) begin
                if (done1 < 0) begin
                    done1 = n;
                    chk("b2b_diff1", 32'(bus.Diff), 30);
                    chk("b2b_bout1", 32'(bus.Bout), 0);
                end else begin
                    done2 = n;
                    chk("b2b_diff2", 32'(bus.Diff), 253);
                    chk("b2b_bout2", 32'(bus.Bout), 1);
                end
            end
            if (done1 >= 0 && n == done1 + 1) bus.Start = 1'b0;
        end
        bus.Start = 1'b0;
        chk("b2b_lat1", done1, W);
        chk("b2b_gap", done2 - done1, W + 1);
        @(posedge clk);
        #1;
        prev_diff = 8'd253;

        // Reset during the 4th SHIFT cycle
        bus.Start = 1'b1;
        bus.Xin   = 8'd60;
        bus.Yin   = 8'd10;
        bus.Bin   = 1'b0;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_busy", 32'(bus.Busy), 0);
        chk("mid_rst_done", 32'(bus.Done), 0);
        chk("mid_rst_diff", 32'(bus.Diff), 0);
        chk("mid_rst_bout", 32'(bus.Bout), 0);
        ndone = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (bus.Done) ndone++;
        end
        chk("mid_rst_nodone", ndone, 0);
        prev_diff = '0;
        run_op(8'd60, 8'd10, 1'b0, d, bo, lat, busyc, hold_ok);
        chk("post_rst_diff", 32'(d), 50);
        chk("post_rst_bout", 32'(bo), 0);
        chk("post_rst_lat", lat, W);
        prev_diff = 8'd50;

        for (int i = 0; i < 500; i++) begin
            logic [W-1:0] rx;
            logic [W-1:0] ry;
            logic         rb;
            rx   = W'($urandom);
            ry   = W'($urandom);
            rb   = 1'($urandom);
            ref9 = {1'b0, rx} - {1'b0, ry} - {8'd0, rb};
            run_op(rx, ry, rb, d, bo, lat, busyc, hold_ok);
            chk($sformatf("rnd%0d_%0d_%0d_%0d", i, rx, ry, rb),
                32'({bo, d}), 32'(ref9));
            if (lat != W) chk($sformatf("rnd%0d_lat", i), lat, W);
            prev_diff = ref9[W-1:0];
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
